hazard_stall_controller: RTL and testbench
==========================================

// Module: hazard_stall_controller
// PURPOSE
//   Pipeline sequencer beside the ALU-operand forwarding logic. Covers hazards that forwarding cannot:
//   - load-use hazards: one-cycle bubble.
//   - multi-cycle memory ops: full freeze.
//   - taken branches: IF/ID and ID/EX flush.
//   - interrupt entry: drain FSM, then a one-cycle acknowledge.
//   Drives stall/flush/bubble enables of the PC and the IF/ID, ID/EX and EX/MEM pipeline registers.
// PARAMETERS
//   REG_ADDR_W      3  register address width
//   INT_DRAIN_CYC   3  cycles fetch is suppressed before int_ack (>=1)
// PORTS
//   clk             in   1           rising-edge clock
//   rst             in   1           synchronous, active-high reset
//   id_src1         in   REG_ADDR_W  ID-stage source 1 address
//   id_src2         in   REG_ADDR_W  ID-stage source 2 address
//   id_src1_used    in   1           ID instruction reads src1
//   id_src2_used    in   1           ID instruction reads src2
//   id_ex_rd        in   REG_ADDR_W  destination of instruction in EX
//   id_ex_mem_read  in   1           EX instruction is a load
//   id_ex_reg_write in   1           EX instruction writes a register
//   mem_busy        in   1           MEM stage needs another cycle (level)
//   branch_taken    in   1           EX resolved a taken branch/jump
//   int_req         in   1           interrupt request pulse
//   pc_stall        out  1           hold PC
//   if_id_stall     out  1           hold IF/ID
//   id_ex_stall     out  1           hold ID/EX
//   ex_mem_stall    out  1           hold EX/MEM
//   id_ex_bubble    out  1           load NOP into ID/EX
//   if_id_flush     out  1           load NOP into IF/ID
//   id_ex_flush     out  1           load NOP into ID/EX (taken branch)
//   int_ack         out  1           interrupt entry complete, one-cycle pulse
//   int_pending     out  1           latched, not yet serviced interrupt
// BEHAVIOUR
//   - Outputs are Mealy: combinational from FSM state and current inputs, same-cycle.
//   - While rst=1: all outputs 0. Next edge: state=RUN, int_pending=0, drain counter=0.
//   - lu = id_ex_mem_read & id_ex_reg_write & ((id_src1_used & id_src1==id_ex_rd) | (id_src2_used & id_src2==id_ex_rd)).
//   - States: RUN, DRAIN, ACK.
//   - Priority inside RUN, per cycle:
//     1. mem_busy=1: pc/if_id/id_ex/ex_mem stalls=1; no bubble, no flush; branch_taken and lu ignored (EX frozen; reevaluated when mem_busy drops).
//     2. branch_taken=1: if_id_flush=1, id_ex_flush=1; lu suppressed (the ID instruction is discarded).
//     3. lu=1: pc_stall=1, if_id_stall=1, id_ex_bubble=1, exactly one cycle. The load then leaves EX, so lu deasserts without extra state.
//     4. Otherwise all outputs 0.
//   - int_req=1 in any state sets int_pending. It is cleared only in ACK.
//   - RUN->DRAIN when int_pending=1 and rows 1-3 are all inactive that cycle. Drain counter loads INT_DRAIN_CYC-1.
//   - DRAIN: pc_stall=1, if_id_flush=1 each cycle; counter decrements.
//     - mem_busy=1 in DRAIN: freeze as row 1, counter holds.
//     - branch_taken in DRAIN: id_ex_flush=1 as well.
//     - DRAIN->ACK when counter==0 and mem_busy=0.
//   - ACK: int_ack=1, pc_stall=0 (PC loads vector externally), if_id_flush=1, int_pending cleared. ACK->RUN unconditionally.
//   - int_req arriving in ACK: re-pends after the clear (set wins over clear), serviced after return to RUN.
//   - rst asserted mid-DRAIN/ACK: aborts to RUN, pending lost, no int_ack.
//   - src==rd compare is full-width; no register is exempt.
// CONFIGURATION
//   - STALL_COUNTERS_EN defined: adds outputs lu_stall_cnt[15:0] and mem_wait_cnt[15:0].
//     - lu_stall_cnt counts cycles with id_ex_bubble=1.
//     - mem_wait_cnt counts cycles with mem_busy-caused freeze.
//     - Both saturate at 16'hFFFF and are cleared by rst.
//   - Undefined: ports and logic absent; all other behaviour identical.
// TESTING
//   - Load r3, next instr reads src2=r3 (used) -> one cycle pc_stall=if_id_stall=id_ex_bubble=1, then all 0.
//   - Same load, consumer src1_used=0 reading r3 via src1 -> no stall.
//   - lu=1 and branch_taken=1 same cycle -> if_id_flush=id_ex_flush=1, id_ex_bubble=0.
//   - mem_busy high 3 cycles with lu=1 -> 4 stalls=1 for 3 cycles, then one bubble cycle.
//   - int_req pulse in RUN, INT_DRAIN_CYC=3:
//     - pc_stall and if_id_flush for 3 cycles.
//     - int_ack on cycle 4, int_pending 0 after.
//   - rst in 2nd DRAIN cycle -> next cycle RUN, outputs 0, int_ack never seen.

Source files
------------

// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: pipeline stall/flush/bubble sequencer for load-use, memory-wait, branch and interrupt-entry hazards
// Ports: clk, rst (sync, active-high); id_src1/2, id_src1/2_used, id_ex_rd, id_ex_mem_read, id_ex_reg_write
// feed load-use detection; mem_busy freezes the pipe; branch_taken flushes IF/ID and ID/EX; int_req pends an
// interrupt that is drained then acknowledged. Outputs: pc/if_id/id_ex/ex_mem stalls, id_ex_bubble,
// if_id_flush, id_ex_flush, int_ack, int_pending. Define STALL_COUNTERS_EN to add lu_stall_cnt and mem_wait_cnt.
module hazard_stall_controller #(
  parameter int REG_ADDR_W    = 3,
  parameter int INT_DRAIN_CYC = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_src1_used,
  input  logic                  id_src2_used,
  input  logic [REG_ADDR_W-1:0] id_ex_rd,
  input  logic                  id_ex_mem_read,
  input  logic                  id_ex_reg_write,
  input  logic                  mem_busy,
  input  logic                  branch_taken,
  input  logic                  int_req,
  output logic                  pc_stall,
  output logic                  if_id_stall,
  output logic                  id_ex_stall,
  output logic                  ex_mem_stall,
  output logic                  id_ex_bubble,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  int_ack,
  output logic                  int_pending
`ifdef STALL_COUNTERS_EN
  ,
  output logic [15:0]           lu_stall_cnt,
  output logic [15:0]           mem_wait_cnt
`endif
);
  localparam int CW = $clog2(INT_DRAIN_CYC + 1);
  typedef enum logic [1:0] {RUN, DRAIN, ACK} state_t;
  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          pend, lu, run, drain, ack, freeze, run_lu, run_br;
  assign lu     = id_ex_mem_read & id_ex_reg_write &
                  ((id_src1_used & (id_src1 == id_ex_rd)) | (id_src2_used & (id_src2 == id_ex_rd)));
  assign run    = state == RUN;
  assign drain  = state == DRAIN;
  assign ack    = state == ACK;
  assign freeze = (run | drain) & mem_busy;
  // a taken branch discards the ID instruction, so it masks the load-use bubble
  assign run_lu = run & ~mem_busy & ~branch_taken & lu;
  assign run_br = run & ~mem_busy & branch_taken;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
      pend  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      pend  <= int_req | (pend & ~ack);
    end
  end
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (run && pend && !mem_busy && !branch_taken && !lu) begin
      state_nx = DRAIN;
      cnt_nx   = CW'(INT_DRAIN_CYC - 1);
    end else if (drain && !mem_busy) begin
      state_nx = cnt == '0 ? ACK : DRAIN;
      cnt_nx   = cnt == '0 ? cnt : cnt - CW'(1);
    end else if (ack) begin
      state_nx = RUN;
    end
  end
  // ACK leaves the PC free so it can load the interrupt vector
  always_comb begin
    pc_stall     = ~rst & (freeze | run_lu | drain);
    if_id_stall  = ~rst & (freeze | run_lu);
    id_ex_stall  = ~rst & freeze;
    ex_mem_stall = ~rst & freeze;
    id_ex_bubble = ~rst & run_lu;
    if_id_flush  = ~rst & (run_br | (drain & ~mem_busy) | ack);
    id_ex_flush  = ~rst & (run | drain) & ~mem_busy & branch_taken;
    int_ack      = ~rst & ack;
    int_pending  = ~rst & pend;
  end
`ifdef STALL_COUNTERS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      lu_stall_cnt <= '0;
      mem_wait_cnt <= '0;
    end else begin
      if (run_lu && lu_stall_cnt != 16'hFFFF) lu_stall_cnt <= lu_stall_cnt + 16'd1;
      if (freeze && mem_wait_cnt != 16'hFFFF) mem_wait_cnt <= mem_wait_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb_hazard_stall_controller: directed scoreboard bench for hazard_stall_controller
module tb_hazard_stall_controller;
  logic       clk = 1'b0, rst = 1'b1;
  logic [2:0] id_src1 = '0, id_src2 = '0, id_ex_rd = '0;
  logic       id_src1_used = 1'b0, id_src2_used = 1'b0, id_ex_mem_read = 1'b0, id_ex_reg_write = 1'b0;
  logic       mem_busy = 1'b0, branch_taken = 1'b0, int_req = 1'b0;
  logic       pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, id_ex_bubble;
  logic       if_id_flush, id_ex_flush, int_ack, int_pending;
`ifdef STALL_COUNTERS_EN
  logic [15:0] lu_stall_cnt, mem_wait_cnt;
`endif
  int n_tests = 0, n_fail = 0;
  logic [8:0] exp_q[$];
  // {pc, if_id, id_ex, ex_mem stall, bubble, if_id_flush, id_ex_flush, int_ack, int_pending}
  localparam logic [8:0] Z  = 9'b0000_0000_0;
  localparam logic [8:0] LU = 9'b1100_1000_0;
  localparam logic [8:0] FL = 9'b0000_0110_0;
  localparam logic [8:0] FZ = 9'b1111_0000_0;
  localparam logic [8:0] P  = 9'b0000_0000_1;
  localparam logic [8:0] D  = 9'b1000_0100_1;
  localparam logic [8:0] DB = 9'b1000_0110_1;
  localparam logic [8:0] A  = 9'b0000_0101_1;
  hazard_stall_controller #(.REG_ADDR_W(3), .INT_DRAIN_CYC(3)) dut (
    .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2),
    .id_src1_used(id_src1_used), .id_src2_used(id_src2_used), .id_ex_rd(id_ex_rd),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_reg_write(id_ex_reg_write), .mem_busy(mem_busy),
    .branch_taken(branch_taken), .int_req(int_req), .pc_stall(pc_stall), .if_id_stall(if_id_stall),
    .id_ex_stall(id_ex_stall), .ex_mem_stall(ex_mem_stall), .id_ex_bubble(id_ex_bubble),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .int_ack(int_ack), .int_pending(int_pending)
`ifdef STALL_COUNTERS_EN
    , .lu_stall_cnt(lu_stall_cnt), .mem_wait_cnt(mem_wait_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask
  // one cycle: drive inputs, queue the expected outputs, compare mid-cycle
  task automatic step(input string tag, input logic r, input logic [2:0] s1, input logic u1,
                      input logic [2:0] s2, input logic u2, input logic [2:0] rd, input logic mr,
                      input logic rw, input logic busy, input logic br, input logic irq,
                      input logic [8:0] exp);
    rst = r; id_src1 = s1; id_src1_used = u1; id_src2 = s2; id_src2_used = u2; id_ex_rd = rd;
    id_ex_mem_read = mr; id_ex_reg_write = rw; mem_busy = busy; branch_taken = br; int_req = irq;
    exp_q.push_back(exp);
    @(negedge clk);
    check(tag, {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, id_ex_bubble,
                if_id_flush, id_ex_flush, int_ack, int_pending}, exp_q.pop_front());
    @(posedge clk);
    #1;
  endtask
  initial begin
    step("rst_gated",  1, 3'd3, 1, 3'd3, 1, 3'd3, 1, 1, 1, 1, 1, Z);
    step("rst_gated2", 1, 3'd3, 1, 3'd3, 1, 3'd3, 1, 1, 0, 0, 0, Z);
    step("idle",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, Z);
    step("lu_src2",    0, 3'd1, 1, 3'd3, 1, 3'd3, 1, 1, 0, 0, 0, LU);
    step("lu_after",   0, 3'd1, 1, 3'd2, 1, 3'd3, 0, 1, 0, 0, 0, Z);
    step("src1_unused",0, 3'd3, 0, 3'd0, 0, 3'd3, 1, 1, 0, 0, 0, Z);
    step("lu_src1",    0, 3'd3, 1, 3'd5, 1, 3'd3, 1, 1, 0, 0, 0, LU);
    step("full_width", 0, 3'd7, 1, 3'd7, 1, 3'd3, 1, 1, 0, 0, 0, Z);
    step("r0_hazard",  0, 3'd0, 1, 3'd4, 0, 3'd0, 1, 1, 0, 0, 0, LU);
    step("no_regwr",   0, 3'd3, 1, 3'd3, 1, 3'd3, 1, 0, 0, 0, 0, Z);
    step("lu_br",      0, 3'd3, 1, 3'd3, 1, 3'd3, 1, 1, 0, 1, 0, FL);
    for (int i = 0; i < 3; i++) step("busy_lu", 0, 3'd3, 1, 3'd0, 0, 3'd3, 1, 1, 1, 0, 0, FZ);
    step("busy_then_lu", 0, 3'd3, 1, 3'd0, 0, 3'd3, 1, 1, 0, 0, 0, LU);
    step("busy_br",    0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, FZ);
    step("br_only",    0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FL);
    step("irq",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, Z);
    step("pend",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, P);
    for (int i = 0; i < 3; i++) step("drain", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, D);
    step("ack",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, A);
    step("post_ack",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, Z);
    step("irq2",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, Z);
    step("pend_lu",    0, 3'd3, 1, 3'd0, 0, 3'd3, 1, 1, 0, 0, 0, LU | P);
    step("pend2",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, P);
    step("drain_a",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, D);
    step("drain_busy", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, FZ | P);
    step("drain_b",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, D);
    step("drain_br",   0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, DB);
    step("ack_irq",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, A);
    step("repend",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, P);
    for (int i = 0; i < 3; i++) step("drain_re", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, D);
    step("ack_re",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, A);
    step("post_re",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, Z);
    step("irq3",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, Z);
    step("pend3",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, P);
    step("drain3",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, D);
    step("rst_drain",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, Z);
    for (int i = 0; i < 5; i++) step("no_ack", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, Z);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
